dmem_mmio_responder: RTL and testbench
======================================

// Module: dmem_mmio_responder
// PURPOSE
//  Responder side of the core's data-memory port: answers mem_write/ALU_result/write_data with read_data.
//  Word RAM plus a small MMIO window: console TX FIFO, status, free-running cycle counter, halt mailbox.
//  Sits beside the core in the top-level; the console drain side goes to the bench or a UART.
// PARAMETERS
//  RAM_WORDS   1024  RAM depth in 32-bit words, power of two; RAM base 0x0000_0000
//  FIFO_DEPTH  8     console FIFO entries, power of two, >=2
//  INIT_FILE   ""    $readmemh image for RAM; empty = no preload
// PORTS
//  clk            in   1   clock, all state on rising edge
//  reset          in   1   asynchronous, active-low (0 = reset)
//  mem_write      in   1   store strobe from core, sampled at posedge
//  addr           in   32  byte address (core ALU_result); addr[1:0] ignored
//  write_data     in   32  store data
//  read_data      out  32  load data, combinational from addr
//  console_data   out  8   FIFO head byte
//  console_valid  out  1   FIFO not empty
//  console_ready  in   1   consumer accepts head this cycle
//  halt           out  1   program wrote TOHOST; sticky until reset
//  halt_code      out  32  value written to TOHOST
// BEHAVIOUR
//  Reset: console_valid=0, halt=0, halt_code=0, cycle=0, FIFO empty, overflow=0. RAM not cleared.
//  Map: 0x0000_0000..RAM_WORDS*4-1 RAM; 0x8000_0000 CONSOLE_TX (W); 0x8000_0004 STATUS (R/W);
//   0x8000_0008 CYCLE (R); 0x8000_000C TOHOST (W). Anything else: reads 0, writes ignored.
//  Reads: zero-latency combinational (single-cycle core). RAM read = word addr[AW+1:2].
//   CONSOLE_TX/TOHOST read 0. STATUS = {29'b0, overflow, full, empty}.
//  Writes: take effect at posedge when mem_write=1 and halt=0; all writes ignored once halt=1.
//   Write/read same RAM word same cycle: read_data shows old value that cycle.
//  CONSOLE_TX write pushes write_data[7:0]. Push accepted if !full, or if full and a pop occurs the same cycle.
//   Rejected push sets sticky overflow; FIFO contents are unchanged.
//  Pop when console_valid && console_ready; console_data must stay stable while valid && !ready.
//  STATUS write with write_data[2]=1 clears overflow; a same-cycle overflow event wins (stays 1).
//  CYCLE: 32-bit, +1 every cycle from reset release while halt=0, wraps 0xFFFF_FFFF->0, frozen after halt.
//  TOHOST write: halt<=1, halt_code<=write_data the next edge; later TOHOST writes ignored.
//  FIFO: read/write pointers with extra wrap bit; full = MSBs differ and rest equal; empty = equal.
//  Reset asserted mid-operation: FIFO flushed, halt cleared immediately (async); RAM keeps contents.
// STRUCTURE
//  Package riscv_mmio_pkg: address constants (RAM_BASE, CONSOLE_TX, STATUS, CYCLE, TOHOST),
//   STATUS bit indices.
//  Sub-module console_fifo (param WIDTH=8, DEPTH): push/pop/full/empty, async active-low reset.
//  Top holds RAM array, address decode, cycle counter, halt mailbox, overflow flag.
// TESTING
//  1 SW 0xDEADBEEF @0x10, then read @0x10 and @0x13 -> read_data=0xDEADBEEF both; @0x14 -> preload/old.
//  2 Write 'H','i' to CONSOLE_TX with console_ready=0 -> valid=1, data=0x48 stable; ready=1 -> 0x48 then 0x69, valid=0.
//  3 FIFO_DEPTH+1 pushes with ready=0 -> STATUS=0b110; write STATUS 0x4 -> 0b010; full push + pop same cycle -> accepted, overflow=0.
//  4 Read CYCLE twice N cycles apart -> difference N; force counter to 0xFFFF_FFFF -> next read 0.
//  5 TOHOST write 0x1 -> next edge halt=1, halt_code=1; later RAM/TOHOST writes ignored, CYCLE frozen.
//  6 Assert reset with 3 bytes queued and halt=1 -> immediately valid=0, halt=0; RAM data preserved.

Source files
------------

// File: rtl/riscv_mmio_pkg.sv
// Address map and STATUS layout shared by the data-memory responder and its console FIFO.
package riscv_mmio_pkg;

  localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] CONSOLE_TX = 32'h8000_0000;
  localparam logic [31:0] STATUS     = 32'h8000_0004;
  localparam logic [31:0] CYCLE      = 32'h8000_0008;
  localparam logic [31:0] TOHOST     = 32'h8000_000C;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;

  typedef enum logic [2:0] {
    SEL_NONE    = 3'd0,
    SEL_RAM     = 3'd1,
    SEL_CONSOLE = 3'd2,
    SEL_STATUS  = 3'd3,
    SEL_CYCLE   = 3'd4,
    SEL_TOHOST  = 3'd5
  } sel_e;

  // Byte offset within a word is ignored for every target, MMIO included.
  function automatic sel_e decode_addr(input logic [31:0] addr, input logic [31:0] ram_bytes);
    sel_e sel;
    if (addr < (RAM_BASE + ram_bytes)) begin
      sel = SEL_RAM;
    end else begin
      case ({addr[31:2], 2'b00})
        CONSOLE_TX: sel = SEL_CONSOLE;
        STATUS:     sel = SEL_STATUS;
        CYCLE:      sel = SEL_CYCLE;
        TOHOST:     sel = SEL_TOHOST;
        default:    sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/console_fifo.sv
// Console TX FIFO: pointers carry an extra wrap bit so full and empty are distinguishable.
module console_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok_s, pop_ok_s;

  assign empty_o   = (wr_q == rd_q);
  assign full_o    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign pop_ok_s  = pop_i && !empty_o;
  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign push_ok_s = push_i && (!full_o || pop_ok_s);
  assign data_o    = mem_q[rd_q[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + (PW+1)'(push_ok_s);
      rd_q <= rd_q + (PW+1)'(pop_ok_s);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_q[PW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM plus console, status, cycle counter and halt mailbox.
module dmem_mmio_responder
  import riscv_mmio_pkg::*;
#(
  parameter int    RAM_WORDS  = 1024,
  parameter int    FIFO_DEPTH = 8,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [7:0]  console_data,
  output logic        console_valid,
  input  logic        console_ready,
  output logic        halt,
  output logic [31:0] halt_code
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0] ram_q [RAM_WORDS];
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] halt_code_q, halt_code_d;
  logic        halt_q, halt_d;
  logic        ovf_q, ovf_d;
  sel_e        sel_s;
  logic        wr_en_s, con_push_s, pop_s, ovf_evt_s, stat_clr_s;
  logic        full_s, empty_s;

  assign sel_s      = decode_addr(addr, 32'(RAM_WORDS * 4));
  assign wr_en_s    = mem_write && !halt_q;
  assign con_push_s = wr_en_s && (sel_s == SEL_CONSOLE);
  assign pop_s      = console_valid && console_ready;
  assign ovf_evt_s  = con_push_s && full_s && !pop_s;
  assign stat_clr_s = wr_en_s && (sel_s == SEL_STATUS) && write_data[STAT_OVF];

  console_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (con_push_s),
    .data_i  (write_data[7:0]),
    .pop_i   (pop_s),
    .data_o  (console_data),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  assign console_valid = !empty_s;
  assign halt          = halt_q;
  assign halt_code     = halt_code_q;

  // Load path is combinational so the single-cycle core sees data in the same cycle.
  always_comb begin
    read_data = 32'h0000_0000;
    case (sel_s)
      SEL_RAM:    read_data = ram_q[addr[AW+1:2]];
      SEL_STATUS: read_data = {29'b0, ovf_q, full_s, empty_s};
      SEL_CYCLE:  read_data = cycle_q;
      default:    read_data = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en_s && (sel_s == SEL_RAM)) begin
      ram_q[addr[AW+1:2]] <= write_data;
    end
  end

  // An overflow in the same cycle as a clear request leaves the flag set.
  always_comb begin
    ovf_d       = ovf_q;
    cycle_d     = halt_q ? cycle_q : cycle_q + 32'd1;
    halt_d      = halt_q;
    halt_code_d = halt_code_q;
    if (ovf_evt_s) begin
      ovf_d = 1'b1;
    end else if (stat_clr_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (wr_en_s && (sel_s == SEL_TOHOST)) begin
      halt_d      = 1'b1;
      halt_code_d = write_data;
    end else begin
      halt_d      = halt_q;
      halt_code_d = halt_code_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q       <= 1'b0;
      cycle_q     <= 32'h0000_0000;
      halt_q      <= 1'b0;
      halt_code_q <= 32'h0000_0000;
    end else begin
      ovf_q       <= ovf_d;
      cycle_q     <= cycle_d;
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Scoreboard bench for dmem_mmio_responder: driver updates a behavioural model, monitor compares at negedge.
module tb_dmem_mmio_responder;

  localparam int DEPTH = 8;
  localparam logic [31:0] A_CON  = 32'h8000_0000;
  localparam logic [31:0] A_STAT = 32'h8000_0004;
  localparam logic [31:0] A_CYC  = 32'h8000_0008;
  localparam logic [31:0] A_HOST = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic [7:0]  console_data;
  logic        console_valid;
  logic        console_ready = 1'b0;
  logic        halt;
  logic [31:0] halt_code;

  dmem_mmio_responder dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .addr(addr),
    .write_data(write_data), .read_data(read_data), .console_data(console_data),
    .console_valid(console_valid), .console_ready(console_ready),
    .halt(halt), .halt_code(halt_code)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0] m_mem [int];
  int          m_cnt = 0;
  bit          m_ovf = 1'b0;
  bit          m_halt = 1'b0;
  logic [31:0] m_code = 32'h0;
  logic [31:0] m_cycle = 32'h0;

  // Scoreboards
  logic [7:0]  sb_con [$];
  logic [31:0] rd_exp [$];
  logic        rd_req = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a < 32'd4096) return m_mem[int'(a[11:2])];
    if (a[31:2] == A_STAT[31:2]) return {29'b0, m_ovf, (m_cnt == DEPTH), (m_cnt == 0)};
    if (a[31:2] == A_CYC[31:2]) return m_cycle;
    return 32'h0;
  endfunction

  task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    bit pop, evt, clr;
    pop = (m_cnt > 0) && rdy;
    evt = 1'b0;
    clr = 1'b0;
    if (!m_halt) m_cycle = m_cycle + 32'd1;
    if (we && !m_halt) begin
      if (a < 32'd4096) m_mem[int'(a[11:2])] = wd;
      else if (a[31:2] == A_CON[31:2]) begin
        if (m_cnt < DEPTH || pop) begin
          sb_con.push_back(wd[7:0]);
          m_cnt++;
        end else evt = 1'b1;
      end
      else if (a[31:2] == A_STAT[31:2]) clr = wd[2];
      else if (a[31:2] == A_HOST[31:2]) begin
        m_halt = 1'b1;
        m_code = wd;
      end
    end
    if (evt) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (pop) m_cnt--;
  endtask

  task automatic model_reset();
    sb_con.delete();
    m_cnt = 0; m_ovf = 1'b0; m_halt = 1'b0; m_code = 32'h0; m_cycle = 32'h0;
  endtask

  // One bus cycle, started just after a posedge; a read expectation is queued for the monitor.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic rdy, input logic chk);
    mem_write = we; addr = a; write_data = wd; console_ready = rdy;
    rd_req = chk;
    if (chk) rd_exp.push_back(model_read(a));
    @(posedge clk);
    model_edge(we, a, wd, rdy);
    #1;
  endtask

  // Monitor: compares read data, console handshakes and halt mailbox against the scoreboards.
  always @(negedge clk) begin
    if (reset) begin
      check("console_valid", {31'b0, console_valid}, {31'b0, (m_cnt != 0)});
      check("halt", {31'b0, halt}, {31'b0, m_halt});
      check("halt_code", halt_code, m_code);
      if (rd_req) begin
        if (rd_exp.size() == 0) check("rd_queue_empty", 32'h1, 32'h0);
        else check("read_data", read_data, rd_exp.pop_front());
      end
      if (console_valid) begin
        if (sb_con.size() == 0) check("console_sb_empty", 32'h1, 32'h0);
        else if (console_ready) check("console_pop", {24'b0, console_data}, {24'b0, sb_con.pop_front()});
        else check("console_hold", {24'b0, console_data}, {24'b0, sb_con[0]});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] odd_addr [6];
    odd_addr[0] = 32'h0000_1000; odd_addr[1] = 32'h8000_0010; odd_addr[2] = 32'h7FFF_FFFC;
    odd_addr[3] = 32'hFFFF_FFF0; odd_addr[4] = A_CON + 32'd2; odd_addr[5] = A_HOST + 32'd1;

    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // RAM write/read, unaligned low bits, read-during-write returns old word
    step(1'b1, 32'h14, 32'h1234_5678, 1'b0, 1'b0);
    step(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0);
    step(1'b0, 32'h10, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h13, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h14, 32'hCAFE_F00D, 1'b0, 1'b1);
    step(1'b0, 32'h14, 32'h0, 1'b0, 1'b1);

    // Console: hold while not ready, then drain
    step(1'b1, A_CON, 32'h48, 1'b0, 1'b0);
    step(1'b1, A_CON, 32'h69, 1'b0, 1'b0);
    repeat (2) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Overflow, clear, full push with simultaneous pop
    for (int i = 0; i <= DEPTH; i++) step(1'b1, A_CON, 32'(i + 8'h30), 1'b0, 1'b0);
    step(1'b0, A_STAT, 32'h0, 1'b0, 1'b1);
    step(1'b1, A_STAT, 32'h4, 1'b0, 1'b0);
    step(1'b0, A_STAT, 32'h0, 1'b0, 1'b1);
    step(1'b1, A_CON, 32'hAA, 1'b1, 1'b0);
    step(1'b0, A_STAT, 32'h0, 1'b0, 1'b1);
    repeat (DEPTH + 1) step(1'b0, A_CYC, 32'h0, 1'b1, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int op;
      logic [31:0] a;
      logic rdy;
      op  = int'($urandom_range(0, 6));
      rdy = ($urandom_range(0, 3) == 0);
      a   = {26'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      case (op)
        0: step(1'b1, a, $urandom, rdy, 1'b0);
        1: step(1'b0, a, 32'h0, rdy, m_mem.exists(int'(a[11:2])));
        2: step(1'b1, A_CON, $urandom, rdy, 1'b0);
        3: step(1'b0, A_STAT, 32'h0, rdy, 1'b1);
        4: step(1'b0, A_CYC, 32'h0, rdy, 1'b1);
        5: step(1'b1, A_STAT, $urandom, rdy, 1'b1);
        default: step(1'b0, odd_addr[$urandom_range(0, 5)], 32'h0, rdy, 1'b1);
      endcase
    end
    repeat (DEPTH + 2) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Cycle counter interval and wrap
    step(1'b0, A_CYC, 32'h0, 1'b0, 1'b1);
    repeat (5) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, A_CYC, 32'h0, 1'b0, 1'b1);
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1 release dut.cycle_q;
    m_cycle = 32'hFFFF_FFFF;
    step(1'b0, A_CYC, 32'h0, 1'b0, 1'b1);
    step(1'b0, A_CYC, 32'h0, 1'b0, 1'b1);

    // Halt mailbox with three bytes queued; later writes ignored, counter frozen
    for (int i = 0; i < 3; i++) step(1'b1, A_CON, 32'(8'h41 + i), 1'b0, 1'b0);
    step(1'b1, A_HOST, 32'h1, 1'b0, 1'b0);
    step(1'b0, A_CYC, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h10, 32'h0BAD_F00D, 1'b0, 1'b0);
    step(1'b1, A_HOST, 32'h2, 1'b0, 1'b0);
    step(1'b1, A_CON, 32'h55, 1'b0, 1'b0);
    step(1'b0, 32'h10, 32'h0, 1'b0, 1'b1);
    step(1'b0, A_CYC, 32'h0, 1'b0, 1'b1);
    step(1'b0, A_STAT, 32'h0, 1'b0, 1'b1);

    // Asynchronous reset mid-operation
    rd_req = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_console_valid", {31'b0, console_valid}, 32'h0);
    check("rst_halt", {31'b0, halt}, 32'h0);
    check("rst_halt_code", halt_code, 32'h0);
    model_reset();
    #1 reset = 1'b1;
    step(1'b0, 32'h10, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h14, 32'h0, 1'b0, 1'b1);
    step(1'b0, A_CYC, 32'h0, 1'b0, 1'b1);
    step(1'b0, A_STAT, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rd_req = 1'b0;
    @(posedge clk);
    check("rd_queue_drained", 32'(rd_exp.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
